ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the EX stage of the 5-stage pipeline. Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers and handles MTHI/MTLO writes. Raises a stall request so the IF/ID/EX registers hold while an operation is in flight or an MFHI/MFLO depends on it. Generalises the single-cycle ALU path to multi-cycle operations, with configurable width and bits retired per cycle.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even, >= 8.
BITS_PER_CYCLE, 1, partial-product/quotient bits retired per iteration; one of 1, 2, 4; WIDTH % BITS_PER_CYCLE == 0.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset
Start  in  1  EX holds a valid mul/div/mthi/mtlo op; sampled only in IDLE
Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op
A  in  WIDTH  rs operand (dividend / multiplicand / MTxx source)
B  in  WIDTH  rt operand (divisor / multiplier)
ReadHiLo  in  1  EX holds MFHI/MFLO
Flush  in  1  branch/jump squash of the op in flight
Stall  out  1  hold upstream pipeline registers
Busy  out  1  operation in progress
Done  out  1  one-cycle pulse when HI/LO commit from mul/div
DivByZero  out  1  one-cycle pulse alongside Done for DIV/DIVU with B==0
HI  out  WIDTH  architectural HI
LO  out  WIDTH  architectural LO

Behaviour:
- Reset (Reset==0 at a rising edge): state IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0, internal accumulators cleared. Reset dominates Flush and Start.
- States: IDLE, ITER, FIXUP.
- IDLE + Start + MTHI/MTLO: HI (or LO) <= A at the next edge; no Busy; Done stays 0.
- IDLE + Start + MULT/MULTU/DIV/DIVU: latch |A|,|B| (signed ops) or raw (unsigned ops), result-sign flags, iteration counter N = WIDTH/BITS_PER_CYCLE; go to ITER, Busy=1 from the next cycle.
- ITER: one step per cycle (shift-add mul / restoring div, BITS_PER_CYCLE bits per step); counter decrements; at counter==1 go to FIXUP.
- FIXUP: apply sign correction and commit HI/LO; Done=1 that cycle; next state IDLE.
- Total latency Start edge -> Done: N + 1 cycles (32-bit, BPC=1: 33). New Start accepted the cycle after Done.
- Signed rules: product negated if sign(A)^sign(B); quotient negated if sign(A)^sign(B); remainder takes sign(A). HI = product[2W-1:W] / remainder; LO = product[W-1:0] / quotient.
- DIV/DIVU with B==0: skip ITER, IDLE -> FIXUP in one cycle; commit LO = all ones, HI = A; DivByZero and Done pulse together.
- DIV of INT_MIN by -1: LO = INT_MIN, HI = 0; no flag.
- Stall = Busy | (Start & op is mul/div & state==IDLE) | (ReadHiLo & Busy). Deasserts in the FIXUP cycle, so MFHI/MFLO in EX reads committed values the next cycle; HI/LO outputs bypass the commit value during FIXUP.
- Start while Busy: ignored (Stall guarantees EX is held; checked by an assertion).
- Flush in ITER or FIXUP: abort, next state IDLE, HI/LO unchanged, no Done. Flush in IDLE cancels a same-cycle Start (including MTHI/MTLO).
- Reset mid-operation: as reset; no Done.
- Op 6/7 with Start: no state change, no Stall.

Decomposition:
- Shared package muldiv_pkg: Op encodings, state encoding, localparam ITER_COUNT = WIDTH/BITS_PER_CYCLE, counter width = $clog2(ITER_COUNT+1).
- One sub-module: muldiv_step (combinational single iteration for BITS_PER_CYCLE bits, mul and div variants selected by a mode input), instantiated once inside the FSM datapath.

Test Plan:
- MULT A=-3 (0xFFFFFFFD), B=7 -> Done after 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB; Stall high 33 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x1234, B=0 -> Done and DivByZero 1 cycle after Start, LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- MTHI A=0xA5A5A5A5 then MFLO-style ReadHiLo while idle -> HI updated next edge, Stall never asserted.
- MULT started, Flush at cycle 10 -> Busy falls next cycle, HI/LO keep prior values, no Done; Reset low at cycle 5 of a DIV -> HI=LO=0, IDLE. Repeat directed set with WIDTH=16, BITS_PER_CYCLE=4 (latency 5).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int count_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// divide, retiring BITS_PER_CYCLE bits per call.
module muldiv_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] wide;

  // Multiply: {hi,lo} holds partial product with the multiplier draining out of lo.
  // Divide: hi is the running remainder, lo shifts the dividend out and quotient in.
  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    wide   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mode_div) begin
        wide   = {hi_out, lo_out[WIDTH-1]};
        lo_out = {lo_out[WIDTH-2:0], 1'b0};
        if (wide >= {1'b0, operand}) begin
          wide      = wide - {1'b0, operand};
          lo_out[0] = 1'b1;
        end
        hi_out = wide[WIDTH-1:0];
      end else begin
        wide   = {1'b0, hi_out} + (lo_out[0] ? {1'b0, operand} : '0);
        hi_out = wide[WIDTH:1];
        lo_out = {wide[0], lo_out[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, handles
// MTHI/MTLO, and stalls the front of the pipeline while an op is in flight.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int ITER_COUNT = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W      = count_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo, operand_q;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;

  logic               a_neg, b_neg, b_zero, start_valid, commit;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   commit_hi, commit_lo;
  logic [2*WIDTH-1:0] prod_fixed;

  // Signed ops iterate on magnitudes; the sign is restored at commit.
  always_comb begin
    a_neg       = is_signed_op(Op) & A[WIDTH-1];
    b_neg       = is_signed_op(Op) & B[WIDTH-1];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    b_zero      = (B == '0);
    start_valid = Start & ~Flush & (state == S_IDLE);
  end

  muldiv_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .mode_div (is_div_q),
    .operand  (operand_q),
    .hi_in    (acc_hi),
    .lo_in    (acc_lo),
    .hi_out   (step_hi),
    .lo_out   (step_lo)
  );

  always_comb begin
    prod_fixed = neg_res_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (is_div_q) begin
      commit_hi = neg_rem_q ? -acc_hi : acc_hi;
      commit_lo = neg_res_q ? -acc_lo : acc_lo;
    end else begin
      commit_hi = prod_fixed[2*WIDTH-1:WIDTH];
      commit_lo = prod_fixed[WIDTH-1:0];
    end
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_valid && is_muldiv_op(Op))
          state_next = (is_div_op(Op) && b_zero) ? S_FIXUP : S_ITER;
      end
      S_ITER: begin
        Busy = 1'b1;
        if (Flush)
          state_next = S_IDLE;
        else if (cnt == CNT_ONE)
          state_next = S_FIXUP;
      end
      S_FIXUP: begin
        commit     = ~Flush & Reset;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    Done      = commit;
    DivByZero = commit & div_zero_q;
    Stall     = Busy | (Start & is_muldiv_op(Op) & (state == S_IDLE)) | (ReadHiLo & Busy);
    // Bypass so an MFHI/MFLO released in the commit cycle sees the new value.
    HI        = commit ? commit_hi : hi_q;
    LO        = commit ? commit_lo : lo_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      operand_q  <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state <= state_next;

      if (start_valid) begin
        if (Op == OP_MTHI) hi_q <= A;
        if (Op == OP_MTLO) lo_q <= A;
        if (is_muldiv_op(Op)) begin
          is_div_q <= is_div_op(Op);
          cnt      <= CNT_INIT;
          if (is_div_op(Op)) begin
            // Divide by zero preloads the architected result and skips iteration.
            operand_q  <= b_mag;
            acc_hi     <= b_zero ? A : '0;
            acc_lo     <= b_zero ? '1 : a_mag;
            neg_res_q  <= ~b_zero & (a_neg ^ b_neg);
            neg_rem_q  <= ~b_zero & a_neg;
            div_zero_q <= b_zero;
          end else begin
            operand_q  <= a_mag;
            acc_hi     <= '0;
            acc_lo     <= b_mag;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
          end
        end
      end

      if (Busy && !Flush) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - CNT_ONE;
      end

      if (commit) begin
        hi_q <= commit_hi;
        lo_q <= commit_lo;
      end
    end
  end

  // Upstream must be frozen whenever a new op shows up mid-iteration.
  a_start_while_busy: assert property (@(posedge Clk) disable iff (!Reset)
    (Start && Busy) |-> Stall);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a 32-bit/1-bit-per-cycle instance and a
// 16-bit/4-bit-per-cycle instance run the same op sequence side by side.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst32, rst16, start32, start16, read_hilo, flush;
  logic [2:0]  op;
  logic [31:0] a32, b32, hi32, lo32;
  logic [15:0] a16, b16, hi16, lo16;
  logic        stall32, busy32, done32, dz32;
  logic        stall16, busy16, done16, dz16;

  int errors = 0;
  int checks = 0;

  int          done32_at, done16_at, done32_n, done16_n, stall32_n, stall16_n;
  logic        dz32_seen, dz16_seen;
  logic [31:0] hi32_done, lo32_done, hi32_c1, hi32_keep, lo32_keep;
  logic [15:0] hi16_done, lo16_done;

  ex_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
    .Clk(Clk), .Reset(rst32), .Start(start32), .Op(op), .A(a32), .B(b32),
    .ReadHiLo(read_hilo), .Flush(flush), .Stall(stall32), .Busy(busy32),
    .Done(done32), .DivByZero(dz32), .HI(hi32), .LO(lo32)
  );

  ex_muldiv_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .Clk(Clk), .Reset(rst16), .Start(start16), .Op(op), .A(a16), .B(b16),
    .ReadHiLo(read_hilo), .Flush(flush), .Stall(stall16), .Busy(busy16),
    .Done(done16), .DivByZero(dz16), .HI(hi16), .LO(lo16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sample(input int cyc);
    if (stall32) stall32_n++;
    if (stall16) stall16_n++;
    if (done32) begin done32_n++; done32_at = cyc; hi32_done = hi32; lo32_done = lo32; end
    if (done16) begin done16_n++; done16_at = cyc; hi16_done = hi16; lo16_done = lo16; end
    if (dz32) dz32_seen = 1'b1;
    if (dz16) dz16_seen = 1'b1;
    if (cyc == 1) hi32_c1 = hi32;
  endtask

  // Present one op to both instances for a single cycle, then watch a fixed window.
  task automatic applyStimulus(input logic [2:0] opv, input logic [31:0] a32v, input logic [31:0] b32v,
                               input logic [15:0] a16v, input logic [15:0] b16v);
    @(negedge Clk);
    op = opv; a32 = a32v; b32 = b32v; a16 = a16v; b16 = b16v;
    start32 = 1'b1; start16 = 1'b1;
    done32_at = -1; done16_at = -1; done32_n = 0; done16_n = 0;
    stall32_n = 0; stall16_n = 0; dz32_seen = 1'b0; dz16_seen = 1'b0;
    #1 sample(0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clk);
      start32 = 1'b0; start16 = 1'b0;
      #1 sample(cyc);
    end
  endtask

  task automatic checkOp(input string name, input int lat32, input int lat16, input int st32, input int st16,
                         input logic dze, input logic [31:0] h32, input logic [31:0] l32,
                         input logic [15:0] h16, input logic [15:0] l16);
    checkOutput({name, " done32 cycle"}, 64'(done32_at), 64'(lat32));
    checkOutput({name, " done16 cycle"}, 64'(done16_at), 64'(lat16));
    checkOutput({name, " done32 pulses"}, 64'(done32_n), 64'((lat32 < 0) ? 0 : 1));
    checkOutput({name, " done16 pulses"}, 64'(done16_n), 64'((lat16 < 0) ? 0 : 1));
    checkOutput({name, " stall32 cycles"}, 64'(stall32_n), 64'(st32));
    checkOutput({name, " stall16 cycles"}, 64'(stall16_n), 64'(st16));
    checkOutput({name, " divbyzero32"}, 64'(dz32_seen), 64'(dze));
    checkOutput({name, " divbyzero16"}, 64'(dz16_seen), 64'(dze));
    checkOutput({name, " HI32"}, 64'(hi32), 64'(h32));
    checkOutput({name, " LO32"}, 64'(lo32), 64'(l32));
    checkOutput({name, " HI16"}, 64'(hi16), 64'(h16));
    checkOutput({name, " LO16"}, 64'(lo16), 64'(l16));
    if (lat32 >= 0) begin
      checkOutput({name, " HI32 bypass at done"}, 64'(hi32_done), 64'(h32));
      checkOutput({name, " LO32 bypass at done"}, 64'(lo32_done), 64'(l32));
    end
    if (lat16 >= 0) begin
      checkOutput({name, " HI16 bypass at done"}, 64'(hi16_done), 64'(h16));
      checkOutput({name, " LO16 bypass at done"}, 64'(lo16_done), 64'(l16));
    end
  endtask

  initial begin
    rst32 = 1'b0; rst16 = 1'b0; start32 = 1'b0; start16 = 1'b0;
    read_hilo = 1'b0; flush = 1'b0; op = 3'd7;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge Clk);
    rst32 = 1'b1; rst16 = 1'b1;
    #1;
    checkOutput("reset HI32", 64'(hi32), 64'h0);
    checkOutput("reset LO32", 64'(lo32), 64'h0);
    checkOutput("reset busy32", 64'(busy32), 64'h0);
    checkOutput("reset done32", 64'(done32), 64'h0);
    checkOutput("reset stall32", 64'(stall32), 64'h0);
    checkOutput("reset HI16", 64'(hi16), 64'h0);
    checkOutput("reset busy16", 64'(busy16), 64'h0);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 16'hFFFD, 16'd7);
    checkOp("MULT -3*7", 33, 5, 33, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 16'hFFFF, 16'hFFEB);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
    checkOp("MULTU max*max", 33, 5, 33, 5, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 16'hFFFE, 16'h0001);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 16'hFFF9, 16'd2);
    checkOp("DIV -7/2", 33, 5, 33, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 16'hFFFF, 16'hFFFD);

    applyStimulus(OP_DIVU, 32'd100, 32'd7, 16'd100, 16'd7);
    checkOp("DIVU 100/7", 33, 5, 33, 5, 1'b0, 32'd2, 32'd14, 16'd2, 16'd14);

    applyStimulus(OP_DIVU, 32'h0000_1234, 32'd0, 16'h1234, 16'd0);
    checkOp("DIVU by zero", 1, 1, 1, 1, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 16'h1234, 16'hFFFF);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 16'h8000, 16'hFFFF);
    checkOp("DIV INT_MIN/-1", 33, 5, 33, 5, 1'b0, 32'h0, 32'h8000_0000, 16'h0, 16'h8000);

    applyStimulus(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 16'hA5A5, 16'h0);
    checkOp("MTHI", -1, -1, 0, 0, 1'b0, 32'hA5A5_A5A5, 32'h8000_0000, 16'hA5A5, 16'h8000);
    checkOutput("MTHI next edge", 64'(hi32_c1), 64'hA5A5_A5A5);

    applyStimulus(OP_MTLO, 32'h5A5A_5A5A, 32'h0, 16'h5A5A, 16'h0);
    checkOp("MTLO", -1, -1, 0, 0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 16'hA5A5, 16'h5A5A);

    @(negedge Clk);
    read_hilo = 1'b1;
    #1;
    checkOutput("ReadHiLo idle stall32", 64'(stall32), 64'h0);
    checkOutput("ReadHiLo idle stall16", 64'(stall16), 64'h0);
    @(negedge Clk);
    read_hilo = 1'b0;

    applyStimulus(3'd6, 32'h1111_1111, 32'h2222_2222, 16'h1111, 16'h2222);
    checkOp("op6 no-op", -1, -1, 0, 0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 16'hA5A5, 16'h5A5A);

    // Flush in IDLE cancels a same-cycle MTHI.
    @(negedge Clk);
    op = OP_MTHI; a32 = 32'hDEAD_BEEF; start32 = 1'b1; flush = 1'b1;
    @(negedge Clk);
    start32 = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flushed MTHI HI32", 64'(hi32), 64'hA5A5_A5A5);

    // Flush a MULT during iteration at cycle 10.
    @(negedge Clk);
    op = OP_MULT; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clk);
      start32 = 1'b0;
    end
    flush = 1'b1;
    #1;
    checkOutput("flush busy before", 64'(busy32), 64'h1);
    @(negedge Clk);
    flush = 1'b0;
    #1;
    checkOutput("flush busy after", 64'(busy32), 64'h0);
    done32_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge Clk);
      #1 if (done32) done32_n++;
    end
    checkOutput("flush no done", 64'(done32_n), 64'h0);
    checkOutput("flush HI32 kept", 64'(hi32), 64'hA5A5_A5A5);
    checkOutput("flush LO32 kept", 64'(lo32), 64'h5A5A_5A5A);

    // Reset at cycle 5 of a DIV.
    @(negedge Clk);
    op = OP_DIV; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge Clk);
      start32 = 1'b0;
    end
    rst32 = 1'b0;
    @(negedge Clk);
    rst32 = 1'b1;
    #1;
    checkOutput("midop reset HI32", 64'(hi32), 64'h0);
    checkOutput("midop reset LO32", 64'(lo32), 64'h0);
    checkOutput("midop reset busy32", 64'(busy32), 64'h0);
    hi32_keep = hi32; lo32_keep = lo32;
    done32_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge Clk);
      #1 if (done32) done32_n++;
    end
    checkOutput("midop reset no done", 64'(done32_n), 64'h0);
    checkOutput("midop reset HI32 stays", 64'(hi32), 64'(hi32_keep));

    applyStimulus(OP_DIVU, 32'd100, 32'd7, 16'd100, 16'd7);
    checkOp("DIVU after reset", 33, 5, 33, 5, 1'b0, 32'd2, 32'd14, 16'd2, 16'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
